// File: rtl/adder_pipe.sv
// Two-stage pipelined add/subtract/accumulate unit with valid/ready handshakes on both sides.
// S1 holds the freshly computed result and S2 drives the outputs.
module adder_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_ACC  = 2'd2,
    MODE_LOAD = 2'd3
  } mode_e;

  mode_e            op;
  logic             accept;
  logic             s2_load;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_c;
  logic             res_carry;
  logic             res_ovf;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_c_q, s1_c_d;
  logic             s1_carry_q, s1_carry_d;
  logic             s1_ovf_q, s1_ovf_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_c_q, s2_c_d;
  logic             s2_carry_q, s2_carry_d;
  logic             s2_ovf_q, s2_ovf_d;

  assign op       = mode_e'(mode);
  assign in_ready = !rst && (!s1_valid_q || !s2_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);

  assign out_valid = s2_valid_q;
  assign c         = s2_c_q;
  assign carry     = s2_carry_q;
  assign ovf       = s2_ovf_q;

  // The accumulator is written on accept, so the next cycle's accumulate sees it directly.
  always_comb begin
    sum       = '0;
    res_c     = a;
    res_carry = 1'b0;
    res_ovf   = 1'b0;
    acc_d     = acc_q;
    unique case (op)
      MODE_ADD: begin
        sum       = {1'b0, a} + {1'b0, b};
        res_c     = sum[MSB:0];
        res_carry = sum[WIDTH];
        res_ovf   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      MODE_SUB: begin
        sum       = {1'b0, a} - {1'b0, b};
        res_c     = sum[MSB:0];
        res_carry = sum[WIDTH];
        res_ovf   = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
      end
      MODE_ACC: begin
        sum       = {1'b0, acc_q} + {1'b0, a};
        res_c     = sum[MSB:0];
        res_carry = sum[WIDTH];
        res_ovf   = (acc_q[MSB] == a[MSB]) && (sum[MSB] != a[MSB]);
        if (accept) acc_d = sum[MSB:0];
      end
      MODE_LOAD: begin
        if (accept) acc_d = a;
      end
      default: ;
    endcase
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_c_d     = s1_c_q;
    s1_carry_d = s1_carry_q;
    s1_ovf_d   = s1_ovf_q;
    s2_valid_d = s2_valid_q;
    s2_c_d     = s2_c_q;
    s2_carry_d = s2_carry_q;
    s2_ovf_d   = s2_ovf_q;

    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_c_d     = s1_c_q;
      s2_carry_d = s1_carry_q;
      s2_ovf_d   = s1_ovf_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    // Data registers keep their last value when a stage empties.
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_c_d     = res_c;
      s1_carry_d = res_carry;
      s1_ovf_d   = res_ovf;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_c_q     <= '0;
      s1_carry_q <= 1'b0;
      s1_ovf_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_c_q     <= '0;
      s2_carry_q <= 1'b0;
      s2_ovf_q   <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      s1_valid_q <= s1_valid_d;
      s1_c_q     <= s1_c_d;
      s1_carry_q <= s1_carry_d;
      s1_ovf_q   <= s1_ovf_d;
      s2_valid_q <= s2_valid_d;
      s2_c_q     <= s2_c_d;
      s2_carry_q <= s2_carry_d;
      s2_ovf_q   <= s2_ovf_d;
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Directed self-checking bench for adder_pipe at WIDTH=4.
// A negedge monitor compares every drained result against a queue of hand-computed values.
module tb_adder_pipe;

  typedef struct packed {
    logic [3:0] c;
    logic       carry;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] c;
  logic       carry;
  logic       ovf;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  logic       stallPrev = 1'b0;
  logic [3:0] heldC;
  logic       heldCarry;
  logic       heldOvf;

  adder_pipe #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .carry     (carry),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Presents one transaction, waits (bounded) for it to be accepted, optionally queues its expected result.
  task automatic applyStimulus(input logic [1:0] m, input logic [3:0] opA, input logic [3:0] opB,
                               input logic [3:0] eC, input logic eCarry, input logic eOvf, input bit track);
    bit done = 0;
    mode     = m;
    a        = opA;
    b        = opB;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        if (track) expQ.push_back('{c: eC, carry: eCarry, ovf: eOvf});
      end
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Results transfer at the posedge following this negedge; stalled outputs must not move.
  always @(negedge clk) begin
    exp_t e;
    if (stallPrev && !rst) begin
      checkOutput("hold_c", c, heldC);
      checkOutput("hold_carry", carry, heldCarry);
      checkOutput("hold_ovf", ovf, heldOvf);
    end
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("stale_output", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("result_c", c, e.c);
        checkOutput("result_carry", carry, e.carry);
        checkOutput("result_ovf", ovf, e.ovf);
      end
    end
    stallPrev = !rst && out_valid === 1'b1 && out_ready === 1'b0;
    heldC     = c;
    heldCarry = carry;
    heldOvf   = ovf;
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    mode      = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_c", c, 0);
    checkOutput("reset_carry", carry, 0);
    checkOutput("reset_ovf", ovf, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", in_ready, 1);

    // Latency: result visible after the second edge.
    applyStimulus(2'd0, 4'd3, 4'd1, 4'd4, 1'b0, 1'b0, 1);
    checkOutput("latency_not_yet", out_valid, 0);
    @(posedge clk);
    #1;
    checkOutput("latency_valid", out_valid, 1);
    checkOutput("latency_c", c, 4);

    applyStimulus(2'd0, 4'd15, 4'd1, 4'd0, 1'b1, 1'b0, 1);
    applyStimulus(2'd0, 4'd7,  4'd1, 4'd8, 1'b0, 1'b1, 1);
    applyStimulus(2'd0, 4'd8,  4'd8, 4'd0, 1'b1, 1'b1, 1);
    applyStimulus(2'd1, 4'd1,  4'd3, 4'd14, 1'b1, 1'b0, 1);
    applyStimulus(2'd1, 4'd8,  4'd1, 4'd7, 1'b0, 1'b1, 1);
    applyStimulus(2'd1, 4'd5,  4'd5, 4'd0, 1'b0, 1'b0, 1);

    applyStimulus(2'd3, 4'd5, 4'd9, 4'd5,  1'b0, 1'b0, 1);
    applyStimulus(2'd2, 4'd6, 4'd9, 4'd11, 1'b0, 1'b1, 1);
    applyStimulus(2'd2, 4'd6, 4'd9, 4'd1,  1'b1, 1'b0, 1);
    applyStimulus(2'd0, 4'd3, 4'd3, 4'd6,  1'b0, 1'b0, 1);
    applyStimulus(2'd2, 4'd2, 4'd9, 4'd3,  1'b0, 1'b0, 1);

    repeat (3) @(posedge clk);
    #1;

    // Backpressure: two accepted, third blocked until the first drains.
    out_ready = 1'b0;
    applyStimulus(2'd0, 4'd2, 4'd2, 4'd4, 1'b0, 1'b0, 1);
    applyStimulus(2'd0, 4'd4, 4'd4, 4'd8, 1'b0, 1'b1, 1);
    mode     = 2'd1;
    a        = 4'd9;
    b        = 4'd4;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_out_valid", out_valid, 1);
    checkOutput("full_c", c, 4);
    @(posedge clk);
    #1;
    mode = 2'd0;
    a    = 4'd15;
    @(negedge clk);
    checkOutput("full_in_ready_2", in_ready, 0);
    @(posedge clk);
    #1;
    mode      = 2'd1;
    a         = 4'd9;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("drain_in_ready", in_ready, 1);
    expQ.push_back('{c: 4'd5, carry: 1'b0, ovf: 1'b1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("drain_queue_empty", expQ.size(), 0);

    // Reset with two transactions in flight; neither may ever appear.
    out_ready = 1'b0;
    applyStimulus(2'd0, 4'd1, 4'd1, 4'd2,  1'b0, 1'b0, 0);
    applyStimulus(2'd2, 4'd7, 4'd0, 4'd10, 1'b0, 1'b0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    rst = 1'b0;
    #1;
    checkOutput("midrst_release_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrst_no_output", out_valid, 0);
    applyStimulus(2'd2, 4'd4, 4'd0, 4'd4, 1'b0, 1'b0, 1);
    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("final_queue_empty", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined successor to the team's combinational 4-bit adder. It adds, subtracts, or accumulates `WIDTH`-bit operands with carry/borrow and signed-overflow flags, behind valid/ready handshakes on both sides. It sits between a stimulus/producer interface and a consumer that may apply backpressure. Latency is 2 cycles, throughput is 1 transaction per cycle, and transactions are never dropped or reordered.

## Interface
- `WIDTH`, default 4: operand and result width in bits (≥ 2).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: producer presents a transaction.
- `in_ready` output 1: block can accept a transaction this cycle.
- `a` input `WIDTH`: operand A.
- `b` input `WIDTH`: operand B; ignored in modes 2 and 3.
- `mode` input 2: 0 = add, 1 = subtract, 2 = accumulate, 3 = load accumulator.
- `out_valid` output 1: result is present on the output.
- `out_ready` input 1: consumer takes the result this cycle.
- `c` output `WIDTH`: result.
- `carry` output 1: carry-out for add/accumulate; borrow for subtract; 0 for load.
- `ovf` output 1: two's-complement signed overflow; 0 for load.

## Operation
- Two register stages, S1 (compute) and S2 (output), each with its own valid bit. `out_valid` is S2's valid; `c`, `carry` and `ovf` are S2's registers.
- Accept: a transaction is accepted when `in_valid && in_ready`. The result is computed combinationally from `a`, `b`, `mode` and `acc`, then registered into S1.
- Mode 0: `{carry, c} = a + b` (WIDTH+1-bit sum). `ovf = (a[MSB] == b[MSB]) && (c[MSB] != a[MSB])`.
- Mode 1: `c = a - b` mod 2^WIDTH. `carry = (a < b)` unsigned (borrow). `ovf = (a[MSB] != b[MSB]) && (c[MSB] != a[MSB])`.
- Mode 2: `{carry, c} = acc + a`; `acc <= c` on accept. `ovf` uses the mode 0 rule with `acc` in place of `b`.
- Mode 3: `acc <= a`; `c = a`; `carry = 0`; `ovf = 0`.
- `acc` is a `WIDTH`-bit internal register. It updates only on an accepted mode 2 or 3 transaction; modes 0 and 1 leave it unchanged. Back-to-back accumulates use the value updated by the previous accept, with no hazard bubble.
- Advance rules:
  - S2 loads from S1 when S1 is valid and (S2 is empty or `out_ready`).
  - S1 loads from the input on accept.
  - S1 clears when it moves to S2 with no new accept in the same cycle.
- `in_ready = !rst && (!s1_valid || !s2_valid || out_ready)`. This is combinational: no combinational path from `in_valid` to `in_ready`, and one path from `out_ready` to `in_ready`.
- Full: S1 and S2 both valid with `out_ready = 0` gives `in_ready = 0`. Data in both stages holds stable.
- Empty: `out_valid = 0`; `c`, `carry` and `ovf` hold their last values.
- Same-cycle accept and drain while full: S2 takes S1, S1 takes the new input, and no bubble is inserted.
- `mode` and operands are sampled only on accept. Changes while `in_ready = 0` have no effect.

## Timing
- Reset (synchronous, takes effect at the rising edge while `rst = 1`):
  - `s1_valid = 0`, `s2_valid = 0`, `out_valid = 0`.
  - `acc = 0`, `c = 0`, `carry = 0`, `ovf = 0`.
  - `in_ready = 0` while `rst = 1`, and 1 on the first cycle after reset is released.
- Reset mid-operation: all in-flight transactions are discarded without being presented and `acc` clears. There is no partial output.
- Latency: for a transaction accepted at edge N with no backpressure, `out_valid` is high after edge N+1 with its result.
- Output hold: while `out_valid && !out_ready`, `c`, `carry` and `ovf` must not change.
- Throughput: 1 transaction per cycle while `out_ready = 1`. Maximum buffering is 2 transactions.

## Test plan
- Basic add, `WIDTH=4`: `a=3`, `b=1`, mode 0 → 2 cycles later `out_valid=1`, `c=4`, `carry=0`, `ovf=0`.
- Add boundaries:
  - `15+1` → `c=0`, `carry=1`, `ovf=0`.
  - `7+1` → `c=8`, `carry=0`, `ovf=1`.
  - `8+8` → `c=0`, `carry=1`, `ovf=1`.
- Subtract:
  - `1-3` → `c=14`, `carry=1`, `ovf=0`.
  - `8-1` → `c=7`, `carry=0`, `ovf=1`.
  - `5-5` → `c=0`, `carry=0`.
- Accumulate, back-to-back:
  - Load 5 (mode 3), then mode 2 with `a=6`, then mode 2 with `a=6` → outputs `c=5`, `c=11`, `c=1` (`carry=1` on the third).
  - Then mode 0 with `3+3` → `c=6`; `acc` stays 1, and a following mode 2 with `a=2` gives `c=3`.
- Backpressure: hold `out_ready=0` and drive 3 consecutive transactions → exactly 2 accepted, then `in_ready=0`. Raise `out_ready` → results drain in order with outputs stable while stalled; the third transaction is accepted in the same cycle the first drains.
- Reset mid-stream: 2 transactions in flight, assert `rst` for 1 cycle → `out_valid=0`, `acc=0`, no stale result ever appears. The next accumulate with `a=4` gives `c=4`.
